// File: rtl/cell_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// cell_dispatcher_pkg
// Shared definitions for the matrix-cell dispatcher slice:
//   - default matrix dimension and element width
//   - 3-bit state encodings for the dispatcher FSM
//   - index_width(): bits needed to count 0..n-1 (never less than 1)
// No ports (package).
// ---------------------------------------------------------------------------
package cell_dispatcher_pkg;

    localparam int default_size       = 2;
    localparam int default_cell_width = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // A 1x1 matrix still needs a one-bit index register.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cell_dispatcher_if.sv
// ---------------------------------------------------------------------------
// cell_dispatcher_if
// Handshake bundle between the dispatcher and the column processor.
//   out_proc_ready : dot-product request (dispatcher -> processor)
//   out_proc_row   : row operand vector
//   out_proc_col   : column operand vector
//   out_proc_ack   : result acknowledge (dispatcher -> processor)
//   in_proc_ready  : result valid (processor -> dispatcher)
//   in_proc_cell   : result, only the low cell_width bits are meaningful
// Modports: master = dispatcher side, slave = processor side.
// ---------------------------------------------------------------------------
interface cell_dispatcher_if
    import cell_dispatcher_pkg::*;
#(
    parameter int width = default_cell_width * default_size
);

    logic             out_proc_ready;
    logic [width-1:0] out_proc_row;
    logic [width-1:0] out_proc_col;
    logic             out_proc_ack;
    logic             in_proc_ready;
    logic [width-1:0] in_proc_cell;

    modport master (
        output out_proc_ready,
        output out_proc_row,
        output out_proc_col,
        output out_proc_ack,
        input  in_proc_ready,
        input  in_proc_cell
    );

    modport slave (
        input  out_proc_ready,
        input  out_proc_row,
        input  out_proc_col,
        input  out_proc_ack,
        output in_proc_ready,
        output in_proc_cell
    );

endinterface

// File: rtl/cell_dispatcher_index_counter.sv
// ---------------------------------------------------------------------------
// dispatch_index_counter
// Row-major (i, j) walker over a size x size matrix.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return to (0,0)
//   advance    : step to the next cell, j fastest, wrapping after the last
//   row_idx    : current i
//   col_idx    : current j
//   last       : high while (i,j) = (size-1, size-1)
// ---------------------------------------------------------------------------
module dispatch_index_counter
    import cell_dispatcher_pkg::*;
#(
    parameter int size  = default_size,
    parameter int idx_w = index_width(default_size)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [idx_w-1:0] row_idx,
    output logic [idx_w-1:0] col_idx,
    output logic             last
);

    localparam logic [idx_w-1:0] last_idx = idx_w'(size - 1);

    assign last = (row_idx == last_idx) && (col_idx == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (clear) begin
            row_idx <= '0;
            col_idx <= '0;
        end else if (advance) begin
            if (col_idx != last_idx) begin
                col_idx <= col_idx + 1'b1;
            end else begin
                col_idx <= '0;
                row_idx <= (row_idx == last_idx) ? '0 : row_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cell_dispatcher.sv
// ---------------------------------------------------------------------------
// cell_dispatcher
// Sequences the cells of C = A x B through an external column processor,
// one dot-product request per cell, and collects the results into C.
//   in_clk       : clock (rising edge)
//   in_reset     : asynchronous active-low reset
//   in_start     : start request, honoured only when idle
//   in_matrix_a  : A, row i at [i*width +: width]
//   in_matrix_b  : B, column j at [j*width +: width]
//   proc         : processor handshake (request/operands, result/ack)
//   out_matrix_c : C, cell (i,j) at [(i*size+j)*cell_width +: cell_width]
//   out_done     : C complete and valid, held until in_done_ack
//   in_done_ack  : consumer release of out_done
// ---------------------------------------------------------------------------
module cell_dispatcher
    import cell_dispatcher_pkg::*;
#(
    parameter int size       = default_size,
    parameter int cell_width = default_cell_width,
    parameter int width      = cell_width * size
)(
    input  logic                             in_clk,
    input  logic                             in_reset,
    input  logic                             in_start,
    input  logic [size*width-1:0]            in_matrix_a,
    input  logic [size*width-1:0]            in_matrix_b,
    cell_dispatcher_if.master                proc,
    output logic [size*size*cell_width-1:0]  out_matrix_c,
    output logic                             out_done,
    input  logic                             in_done_ack
);

    localparam int idx_w = index_width(size);

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [size*width-1:0] a_reg;
    logic [size*width-1:0] b_reg;
    logic [idx_w-1:0]      row_idx;
    logic [idx_w-1:0]      col_idx;
    logic                  last_cell;
    logic                  accept_start;
    logic                  capture;
    int                    row_base;
    int                    col_base;
    int                    cell_base;
    logic                  unused_cell_bits;

    assign accept_start = (state == S_IDLE) && in_start;
    assign capture      = (state == S_WAIT) && proc.in_proc_ready;

    assign row_base  = int'(32'(row_idx)) * width;
    assign col_base  = int'(32'(col_idx)) * width;
    assign cell_base = (int'(32'(row_idx)) * size + int'(32'(col_idx))) * cell_width;

    // The processor result bus is full vector width; only the low cell is kept.
    assign unused_cell_bits = ^proc.in_proc_cell;

    dispatch_index_counter #(
        .size  (size),
        .idx_w (idx_w)
    ) u_index (
        .clk     (in_clk),
        .rst_n   (in_reset),
        .clear   (accept_start),
        .advance (state == S_GAP),
        .row_idx (row_idx),
        .col_idx (col_idx),
        .last    (last_cell)
    );

    // Next-state logic. S_GAP exists because the processor's result-valid is
    // registered and is still high for one cycle after our acknowledge.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_start) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (proc.in_proc_ready) next_state = S_ACK;
            S_ACK:   next_state = S_GAP;
            S_GAP:   next_state = last_cell ? S_DONE : S_ISSUE;
            S_DONE:  if (in_done_ack) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand snapshot taken at start so later input changes cannot disturb
    // a computation in flight.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (accept_start) begin
            a_reg <= in_matrix_a;
            b_reg <= in_matrix_b;
        end
    end

    // Result matrix: cleared on start, one cell written per processor result,
    // otherwise held (including while idle after completion).
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            out_matrix_c <= '0;
        end else if (accept_start) begin
            out_matrix_c <= '0;
        end else if (capture) begin
            out_matrix_c[cell_base +: cell_width] <= proc.in_proc_cell[cell_width-1:0];
        end
    end

    // Operands come straight from the snapshot and the indices, both of which
    // are frozen from issue until the cell is captured.
    assign proc.out_proc_row   = a_reg[row_base +: width];
    assign proc.out_proc_col   = b_reg[col_base +: width];
    assign proc.out_proc_ready = (state == S_ISSUE);
    assign proc.out_proc_ack   = (state == S_ACK);
    assign out_done            = (state == S_DONE);

endmodule

// File: tb/tb_cell_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_cell_dispatcher
// Self-checking bench for cell_dispatcher (size=2, cell_width=8) with a
// behavioural column processor and a result scoreboard.
// ---------------------------------------------------------------------------
module tb_cell_dispatcher;

    localparam int SIZE = 2;
    localparam int CW   = 8;
    localparam int W    = CW * SIZE;
    localparam int MW   = SIZE * W;
    localparam int CWID = SIZE * SIZE * CW;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            start    = 1'b0;
    logic            done_ack = 1'b0;
    logic [MW-1:0]   mat_a    = '0;
    logic [MW-1:0]   mat_b    = '0;
    logic [CWID-1:0] mat_c;
    logic            done;

    int checks = 0;
    int errors = 0;
    int hold_cycles = 0;

    int req_pulses = 0;
    int ack_pulses = 0;
    int wide_errs  = 0;
    int gap_errs   = 0;

    logic [CW-1:0] exp_q[$];

    // A rows (1,2),(3,4); B columns (5,7),(6,8)
    localparam logic [MW-1:0] MAT1_A = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [MW-1:0] MAT1_B = {8'd8, 8'd6, 8'd7, 8'd5};
    // A rows (200,100),(255,1); B columns (3,2),(255,255): exercises truncation
    localparam logic [MW-1:0] MAT2_A = {8'd1, 8'd255, 8'd100, 8'd200};
    localparam logic [MW-1:0] MAT2_B = {8'd255, 8'd255, 8'd2, 8'd3};
    localparam logic [MW-1:0] JUNK   = {8'd99, 8'd98, 8'd97, 8'd96};

    cell_dispatcher_if #(.width(W)) proc ();

    cell_dispatcher #(
        .size       (SIZE),
        .cell_width (CW),
        .width      (W)
    ) dut (
        .in_clk       (clk),
        .in_reset     (rst_n),
        .in_start     (start),
        .in_matrix_a  (mat_a),
        .in_matrix_b  (mat_b),
        .proc         (proc),
        .out_matrix_c (mat_c),
        .out_done     (done),
        .in_done_ack  (done_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [CW-1:0] dot(input logic [W-1:0] r, input logic [W-1:0] c);
        int s;
        s = 0;
        for (int k = 0; k < SIZE; k++)
            s += int'(r[k*CW +: CW]) * int'(c[k*CW +: CW]);
        return CW'(s);
    endfunction

    function automatic logic [CW-1:0] ref_cell(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                                input int i, input int j);
        return dot(a[i*W +: W], b[j*W +: W]);
    endfunction

    // Processor: samples operands one cycle after the request, waits
    // hold_cycles, raises result-valid with junk upper bits, and drops it one
    // cycle after seeing the acknowledge.
    initial begin : processor_model
        int p_state;
        int delay;
        logic [CW-1:0] res;
        p_state = 0;
        delay = 0;
        res = '0;
        proc.in_proc_ready = 1'b0;
        proc.in_proc_cell  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n !== 1'b1) begin
                p_state = 0;
                proc.in_proc_ready = 1'b0;
            end else begin
                case (p_state)
                    0: if (proc.out_proc_ready === 1'b1) p_state = 1;
                    1: begin
                        res = dot(proc.out_proc_row, proc.out_proc_col);
                        delay = hold_cycles;
                        p_state = 2;
                    end
                    2: if (delay == 0) begin
                        proc.in_proc_cell  = {8'hA5, res};
                        proc.in_proc_ready = 1'b1;
                        p_state = 3;
                    end else begin
                        delay--;
                    end
                    3: if (proc.out_proc_ack === 1'b1) p_state = 4;
                    4: begin
                        proc.in_proc_ready = 1'b0;
                        p_state = 0;
                    end
                    default: p_state = 0;
                endcase
            end
        end
    end

    // Pulse monitor: counts request/ack pulses, flags pulses wider than one
    // cycle and any request in the cycle right after an acknowledge.
    initial begin : pulse_monitor
        logic prev_ready;
        logic prev_ack;
        prev_ready = 1'b0;
        prev_ack   = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (proc.out_proc_ready === 1'b1 && prev_ready !== 1'b1) req_pulses++;
            if (proc.out_proc_ack === 1'b1 && prev_ack !== 1'b1) ack_pulses++;
            if (proc.out_proc_ready === 1'b1 && prev_ready === 1'b1) wide_errs++;
            if (proc.out_proc_ack === 1'b1 && prev_ack === 1'b1) wide_errs++;
            if (proc.out_proc_ready === 1'b1 && prev_ack === 1'b1) gap_errs++;
            prev_ready = proc.out_proc_ready;
            prev_ack   = proc.out_proc_ack;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_run(input logic [MW-1:0] a, input logic [MW-1:0] b);
        mat_a = a;
        mat_b = b;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                exp_q.push_back(ref_cell(a, b, i, j));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_request(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (proc.out_proc_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic release_done();
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b0;
        start = 1'b1;
        mat_a = MAT1_A;
        mat_b = MAT1_B;
        repeat (3) tick();
        checks++;
        if ({proc.out_proc_ready, proc.out_proc_ack, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: ready/ack/done got %b expected 000",
                     {proc.out_proc_ready, proc.out_proc_ack, done});
        end
        checks++;
        if (proc.out_proc_row !== '0 || proc.out_proc_col !== '0 || mat_c !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: row %h col %h c %h expected all 0",
                     proc.out_proc_row, proc.out_proc_col, mat_c);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (proc.out_proc_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: ready %b done %b expected 0 0",
                     proc.out_proc_ready, done);
        end
    endtask

    task automatic test_full_compute();
        bit ok;
        int req0, ack0, wide0, gap0;
        logic [CW-1:0] exp;
        $display("[TB] test_full_compute");
        hold_cycles = 0;
        req0 = req_pulses; ack0 = ack_pulses; wide0 = wide_errs; gap0 = gap_errs;
        start_run(MAT1_A, MAT1_B);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            wait_request(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL full_req_timeout: cell %0d got no request expected one", c);
            end else begin
                checks++;
                if (proc.out_proc_row !== MAT1_A[(c/SIZE)*W +: W] ||
                    proc.out_proc_col !== MAT1_B[(c%SIZE)*W +: W]) begin
                    errors++;
                    $display("[TB] FAIL full_operands: cell %0d got %h/%h expected %h/%h", c,
                             proc.out_proc_row, proc.out_proc_col,
                             MAT1_A[(c/SIZE)*W +: W], MAT1_B[(c%SIZE)*W +: W]);
                end
            end
        end
        wait_done(ok);
        checks++;
        if (!ok || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_done: got %b expected 1", done);
        end
        for (int c = 0; c < 4; c++) begin
            exp = exp_q.pop_front();
            checks++;
            if (mat_c[c*CW +: CW] !== exp) begin
                errors++;
                $display("[TB] FAIL full_cell: cell %0d got %0d expected %0d", c, mat_c[c*CW +: CW], exp);
            end
        end
        checks++;
        if (req_pulses - req0 != 4 || ack_pulses - ack0 != 4) begin
            errors++;
            $display("[TB] FAIL pulse_count: req %0d ack %0d expected 4 4",
                     req_pulses - req0, ack_pulses - ack0);
        end
        checks++;
        if (wide_errs != wide0 || gap_errs != gap0) begin
            errors++;
            $display("[TB] FAIL pulse_shape: wide %0d gap_req %0d expected 0 0",
                     wide_errs - wide0, gap_errs - gap0);
        end
        release_done();
    endtask

    task automatic test_wait_hold();
        bit ok;
        logic [W-1:0] row0, col0;
        logic [CW-1:0] exp;
        $display("[TB] test_wait_hold");
        hold_cycles = 10;
        start_run(MAT1_A, MAT1_B);
        wait_request(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL hold_req_timeout: got no request expected one");
        end
        row0 = MAT1_A[0 +: W];
        col0 = MAT1_B[0 +: W];
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (proc.out_proc_ack !== 1'b0 || proc.out_proc_ready !== 1'b0 ||
                proc.out_proc_row !== row0 || proc.out_proc_col !== col0) begin
                errors++;
                $display("[TB] FAIL hold_wait: cycle %0d ack %b req %b row %h col %h expected 0 0 %h %h",
                         k, proc.out_proc_ack, proc.out_proc_ready,
                         proc.out_proc_row, proc.out_proc_col, row0, col0);
            end
        end
        hold_cycles = 0;
        for (int c = 1; c < 4; c++) begin
            tick();
            wait_request(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL hold_req_timeout: cell %0d got no request expected one", c);
            end
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL hold_done: got %b expected 1", done);
        end
        for (int c = 0; c < 4; c++) begin
            exp = exp_q.pop_front();
            checks++;
            if (mat_c[c*CW +: CW] !== exp) begin
                errors++;
                $display("[TB] FAIL hold_cell: cell %0d got %0d expected %0d", c, mat_c[c*CW +: CW], exp);
            end
        end
        release_done();
    endtask

    task automatic test_start_ignored();
        bit ok;
        int req0;
        logic [CW-1:0] exp;
        $display("[TB] test_start_ignored");
        hold_cycles = 0;
        req0 = req_pulses;
        start_run(MAT1_A, MAT1_B);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            wait_request(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL ign_req_timeout: cell %0d got no request expected one", c);
            end else begin
                checks++;
                if (proc.out_proc_row !== MAT1_A[(c/SIZE)*W +: W] ||
                    proc.out_proc_col !== MAT1_B[(c%SIZE)*W +: W]) begin
                    errors++;
                    $display("[TB] FAIL ign_operands: cell %0d got %h/%h expected %h/%h", c,
                             proc.out_proc_row, proc.out_proc_col,
                             MAT1_A[(c/SIZE)*W +: W], MAT1_B[(c%SIZE)*W +: W]);
                end
            end
            if (c == 1) begin
                mat_a = JUNK;
                mat_b = JUNK;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL ign_done: got %b expected 1", done);
        end
        for (int c = 0; c < 4; c++) begin
            exp = exp_q.pop_front();
            checks++;
            if (mat_c[c*CW +: CW] !== exp) begin
                errors++;
                $display("[TB] FAIL ign_cell: cell %0d got %0d expected %0d", c, mat_c[c*CW +: CW], exp);
            end
        end
        checks++;
        if (req_pulses - req0 != 4) begin
            errors++;
            $display("[TB] FAIL ign_req_count: got %0d expected 4", req_pulses - req0);
        end
        release_done();
    endtask

    task automatic test_done_hold();
        bit ok;
        int req0;
        logic [CW-1:0] exp;
        $display("[TB] test_done_hold");
        hold_cycles = 0;
        start_run(MAT1_A, MAT1_B);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL dh_done: got %b expected 1", done);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL dh_hold: cycle %0d got %b expected 1", k, done);
            end
        end
        // Acknowledge and a new start together: only the release may happen.
        done_ack = 1'b1;
        start = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dh_release: got %b expected 0", done);
        end
        done_ack = 1'b0;
        start = 1'b0;
        req0 = req_pulses;
        repeat (4) tick();
        checks++;
        if (req_pulses != req0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dh_no_restart: req %0d done %b expected 0 0", req_pulses - req0, done);
        end
        for (int c = 0; c < 4; c++) begin
            exp = exp_q.pop_front();
            checks++;
            if (mat_c[c*CW +: CW] !== exp) begin
                errors++;
                $display("[TB] FAIL dh_idle_cell: cell %0d got %0d expected %0d", c, mat_c[c*CW +: CW], exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int ack0;
        logic [CW-1:0] exp;
        $display("[TB] test_reset_mid");
        hold_cycles = 3;
        start_run(MAT1_A, MAT1_B);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            wait_request(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL rm_req_timeout: cell %0d got no request expected one", c);
            end
        end
        ack0 = ack_pulses;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({proc.out_proc_ready, proc.out_proc_ack, done} !== 3'b000 ||
            proc.out_proc_row !== '0 || proc.out_proc_col !== '0 || mat_c !== '0) begin
            errors++;
            $display("[TB] FAIL rm_immediate: ctrl %b row %h col %h c %h expected all 0",
                     {proc.out_proc_ready, proc.out_proc_ack, done},
                     proc.out_proc_row, proc.out_proc_col, mat_c);
        end
        repeat (3) tick();
        checks++;
        if (ack_pulses != ack0) begin
            errors++;
            $display("[TB] FAIL rm_no_ack: got %0d acks expected 0", ack_pulses - ack0);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        hold_cycles = 0;
        start_run(MAT2_A, MAT2_B);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            wait_request(ok);
            checks++;
            if (!ok || proc.out_proc_row !== MAT2_A[(c/SIZE)*W +: W] ||
                proc.out_proc_col !== MAT2_B[(c%SIZE)*W +: W]) begin
                errors++;
                $display("[TB] FAIL rm_operands: cell %0d got %h/%h expected %h/%h", c,
                         proc.out_proc_row, proc.out_proc_col,
                         MAT2_A[(c/SIZE)*W +: W], MAT2_B[(c%SIZE)*W +: W]);
            end
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL rm_done: got %b expected 1", done);
        end
        for (int c = 0; c < 4; c++) begin
            exp = exp_q.pop_front();
            checks++;
            if (mat_c[c*CW +: CW] !== exp) begin
                errors++;
                $display("[TB] FAIL rm_cell: cell %0d got %0d expected %0d", c, mat_c[c*CW +: CW], exp);
            end
        end
        release_done();
    endtask

    initial begin
        test_reset();
        test_full_compute();
        test_wait_hold();
        test_start_ignored();
        test_done_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cell_dispatcher.md
CELL_DISPATCHER -- requirements
Module: cell_dispatcher

Interface
REQ-001 The block SHALL have parameter size, default 2: matrix dimension (rows = columns = size).
REQ-002 The block SHALL have parameter cell_width, default 8: bits per matrix element.
REQ-003 The block SHALL have parameter width, default cell_width*size: bits per row/column vector.
REQ-004 The block SHALL have port in_clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port in_reset, input, 1, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port in_start, input, 1, a request to compute C = A x B.
REQ-007 The block SHALL have port in_matrix_a, input, size*width: row i at [i*width +: width], element k at [k*cell_width +: cell_width] within the row.
REQ-008 The block SHALL have port in_matrix_b, input, size*width: column j at [j*width +: width], packed the same way as rows.
REQ-009 The block SHALL have port out_proc_ready, output, 1, a dot-product request to the column processor.
REQ-010 The block SHALL have ports out_proc_row and out_proc_col, output, width each: operand vectors for the current request.
REQ-011 The block SHALL have port in_proc_ready, input, 1, the processor's result-valid signal.
REQ-012 The block SHALL have port in_proc_cell, input, width: the processor result; only bits [cell_width-1:0] are significant.
REQ-013 The block SHALL have port out_proc_ack, output, 1, the result acknowledge to the processor.
REQ-014 The block SHALL have port out_matrix_c, output, size*size*cell_width: cell (i,j) at [(i*size+j)*cell_width +: cell_width].
REQ-015 The block SHALL have port out_done, output, 1, meaning out_matrix_c is complete and valid.
REQ-016 The block SHALL have port in_done_ack, input, 1, the consumer's release of out_done.

Function
REQ-017 The block SHALL use the states S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_GAP and S_DONE.
REQ-018 In S_IDLE, when in_start=1 the block SHALL register in_matrix_a and in_matrix_b, clear indices i=j=0, clear out_matrix_c and go to S_ISSUE.
REQ-019 In any state other than S_IDLE, in_start SHALL be ignored, and changes on in_matrix_a/in_matrix_b SHALL not affect the computation.
REQ-020 In S_ISSUE, out_proc_ready SHALL be 1 for exactly one cycle, with out_proc_row = row i and out_proc_col = column j; the next state SHALL be S_WAIT.
REQ-021 out_proc_row and out_proc_col SHALL stay stable from S_ISSUE until the result is captured, because the processor samples the operands one cycle after the request.
REQ-022 In S_WAIT, when in_proc_ready=1 the block SHALL write in_proc_cell[cell_width-1:0] into cell (i,j) and go to S_ACK; otherwise it SHALL remain in S_WAIT with no timeout.
REQ-023 In S_ACK, out_proc_ack SHALL be 1 for exactly one cycle; the next state SHALL be S_GAP.
REQ-024 In S_GAP, the block SHALL ignore in_proc_ready for one cycle, because that signal is still registered high while the processor returns to idle.
REQ-025 At S_GAP exit, if j<size-1 then j SHALL increment; otherwise j SHALL become 0 and i SHALL increment; the next state SHALL be S_ISSUE.
REQ-026 At S_GAP exit with (i,j) = (size-1,size-1), the next state SHALL be S_DONE instead of S_ISSUE.
REQ-027 In S_DONE, out_done SHALL be 1 and out_matrix_c SHALL be held until in_done_ack=1; the block SHALL then go to S_IDLE and drop out_done on the next cycle.
REQ-028 out_matrix_c SHALL retain its final value in S_IDLE until the next accepted in_start.
REQ-029 Per-cell latency SHALL be 3 + (cycles in S_WAIT); there SHALL be no arithmetic beyond index math, and results SHALL be truncated to cell_width bits.
REQ-030 in_start and in_done_ack asserted together in S_DONE SHALL produce only the return to S_IDLE; the new start is accepted only when it is seen in S_IDLE.

Reset
REQ-031 While in_reset=0, regardless of the clock, the state SHALL be S_IDLE, i=j=0, and out_proc_ready, out_proc_ack and out_done SHALL be 0.
REQ-032 While in_reset=0, out_proc_row, out_proc_col, out_matrix_c and the captured operands SHALL be 0.
REQ-033 A reset mid-operation SHALL abort without issuing an acknowledge; the processor is reset by the same in_reset.

Structure
REQ-034 A shared package SHALL hold the state encodings (3-bit) and the default size and cell_width constants.
REQ-035 The block SHALL instantiate one sub-module, dispatch_index_counter: an i/j counter with advance input and last-cell flag.

Verification
REQ-036 The bench SHALL drive size=2, cell_width=8, A rows (1,2),(3,4) and B columns (5,7),(6,8) with a processor model, and SHALL check that out_matrix_c cells (0,0),(0,1),(1,0),(1,1) = 19,22,43,50 with out_done=1.
REQ-037 The bench SHALL hold processor in_proc_ready low for 10 cycles, and SHALL check that the block stays in S_WAIT with operands stable and out_proc_ack=0.
REQ-038 The bench SHALL check that out_proc_ready pulses exactly 4 times and out_proc_ack exactly 4 times, each pulse 1 cycle wide, with no request during S_GAP.
REQ-039 The bench SHALL pulse in_start again while cell (0,1) is pending, and SHALL check that it is ignored and the results are unchanged.
REQ-040 The bench SHALL assert in_reset=0 during cell (1,0), and SHALL check that all outputs go to 0 immediately; after release plus in_start, the bench SHALL check that a correct full result is produced.
REQ-041 The bench SHALL hold in_done_ack=0 for 5 cycles in S_DONE, and SHALL check that out_done stays 1; after in_done_ack=1 it SHALL check that out_done=0 one cycle later.
